// File: rtl/exec_pkg.sv
// Shared encodings for the execute unit: opcode[6:2] values, func3 codes for
// ALU/branch/M ops, and the mul/div sequencing state type.
package exec_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_m_op(input logic [4:0] opcode, input logic f7_25,
                                     input logic f7_30);
        return (opcode == OP_R) && f7_25 && !f7_30;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// Request/result bundle between the EX stage and the execute unit.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the
// source holds its payload stable while valid && !ready and never drops valid early.
interface alu_muldiv_iter_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic            func7_30;
    logic            func7_25;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            alubranch;

    modport slave (
        input  in_valid, opcode, func3, func7_30, func7_25, operand1, operand2, out_ready,
        output in_ready, out_valid, alu_out, alubranch
    );

    modport master (
        output in_valid, opcode, func3, func7_30, func7_25, operand1, operand2, out_ready,
        input  in_ready, out_valid, alu_out, alubranch
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand
// magnitudes, retiring STEP bits per cycle; sign correction applied on the result.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int ITERS = XLEN / STEP;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic              running;
    logic              neg_res;
    logic              neg_rem;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod, prod_n;
    logic [2*XLEN-1:0] mcand, mcand_n;
    logic [XLEN-1:0]   sh, sh_n;
    logic [XLEN-1:0]   rem, rem_n;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN:0]     trial;
    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   quo, rmd;

    // Signedness of each operand by op; division sign rules mirror DIV/REM.
    always_comb begin
        sgn_a = op[2] ? !op[0] : ((op == F3_MULH) || (op == F3_MULHSU));
        sgn_b = op[2] ? !op[0] : (op == F3_MULH);
        a_neg = sgn_a && a[XLEN-1];
        b_neg = sgn_b && b[XLEN-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // sh holds the multiplier (consumed LSB first) or the dividend/quotient.
    always_comb begin
        prod_n  = prod;
        mcand_n = mcand;
        sh_n    = sh;
        rem_n   = rem;
        trial   = '0;
        for (int i = 0; i < STEP; i++) begin
            if (op_q[2]) begin
                trial = {rem_n, sh_n[XLEN-1]};
                sh_n  = {sh_n[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, dvsr}) begin
                    trial   = trial - {1'b0, dvsr};
                    sh_n[0] = 1'b1;
                end
                rem_n = trial[XLEN-1:0];
            end else begin
                if (sh_n[0]) prod_n = prod_n + mcand_n;
                mcand_n = mcand_n << 1;
                sh_n    = sh_n >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            op_q    <= '0;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            sh      <= '0;
            rem     <= '0;
            dvsr    <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            op_q    <= op;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, mag_a};
            sh      <= op[2] ? mag_a : mag_b;
            rem     <= '0;
            dvsr    <= mag_b;
        end else if (running) begin
            prod  <= prod_n;
            mcand <= mcand_n;
            sh    <= sh_n;
            rem   <= rem_n;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) running <= 1'b0;
        end
    end

    assign done = running && (cnt == LAST);

    always_comb begin
        full = neg_res ? -prod : prod;
        quo  = neg_res ? -sh : sh;
        rmd  = neg_rem ? -rem : rem;
        case (op_q)
            F3_MUL:                         result = full[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   result = full[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                result = quo;
            default:                        result = rmd;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_iter.sv
// EX-stage execute unit: single-cycle RV base ALU plus iterative M-extension,
// with a registered result behind a valid/ready handshake.
module alu_muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_muldiv_iter_if.slave bus,
    output logic             busy,
    output state_t           fsm_state
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_next;
    logic            out_valid;
    logic [XLEN-1:0] alu_out_q;
    logic            alubranch_q;
    logic [XLEN-1:0] op1, op2;
    logic [2:0]      func3;
    logic [SHW-1:0]  shamt;
    logic            in_ready, accept, is_m, special;
    logic [XLEN-1:0] base_res, special_res, res_val;
    logic            base_br, res_br, load_res, md_start, md_done;
    logic [XLEN-1:0] md_result;

    assign op1   = bus.operand1;
    assign op2   = bus.operand2;
    assign func3 = bus.func3;
    assign shamt = op2[SHW-1:0];

    assign in_ready = !rst && (state == S_IDLE) && (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready && !flush;
    assign is_m     = is_m_op(bus.opcode, bus.func7_25, bus.func7_30);

    always_comb begin
        base_res = op1 + op2;
        base_br  = 1'b0;
        case (bus.opcode)
            OP_R, OP_I: begin
                case (func3)
                    F3_ADD:  base_res = (bus.opcode == OP_R && bus.func7_30) ? op1 - op2 : op1 + op2;
                    F3_SLL:  base_res = op1 << shamt;
                    F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
                    F3_SLTU: base_res = {{(XLEN-1){1'b0}}, op1 < op2};
                    F3_XOR:  base_res = op1 ^ op2;
                    F3_SR:   base_res = bus.func7_30 ? $unsigned($signed(op1) >>> shamt)
                                                     : op1 >> shamt;
                    F3_OR:   base_res = op1 | op2;
                    default: base_res = op1 & op2;
                endcase
            end
            OP_LUI: base_res = op2;
            OP_JAL, OP_JALR: begin
                base_res = op1 + XLEN'(4);
                base_br  = 1'b1;
            end
            OP_BRANCH: begin
                case (func3)
                    F3_BEQ:  base_br = (op1 == op2);
                    F3_BNE:  base_br = (op1 != op2);
                    F3_BLT:  base_br = ($signed(op1) < $signed(op2));
                    F3_BGE:  base_br = ($signed(op1) >= $signed(op2));
                    F3_BLTU: base_br = (op1 < op2);
                    F3_BGEU: base_br = (op1 >= op2);
                    default: base_br = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // Divide-by-zero and signed overflow have fixed answers; skip the iteration.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (is_m && func3[2]) begin
            if (op2 == '0) begin
                special     = 1'b1;
                special_res = func3[1] ? op1 : '1;
            end else if (!func3[0] && (op1 == MIN_INT) && (op2 == '1)) begin
                special     = 1'b1;
                special_res = func3[1] ? '0 : MIN_INT;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_res   = 1'b0;
        res_val    = base_res;
        res_br     = base_br;
        md_start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_m && !special) begin
                        md_start   = 1'b1;
                        state_next = func3[2] ? S_DIV : S_MUL;
                    end else begin
                        load_res = 1'b1;
                        if (is_m) begin
                            res_val = special_res;
                            res_br  = 1'b0;
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_done) state_next = S_DONE;
            end
            default: begin
                load_res   = 1'b1;
                res_val    = md_result;
                res_br     = 1'b0;
                state_next = S_IDLE;
            end
        endcase
        if (flush) begin
            state_next = S_IDLE;
            load_res   = 1'b0;
            md_start   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new result may load in the same cycle the old one retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_out_q   <= '0;
            alubranch_q <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_res) begin
            out_valid   <= 1'b1;
            alu_out_q   <= res_val;
            alubranch_q <= res_br;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .abort  (flush),
        .op     (func3),
        .a      (op1),
        .b      (op2),
        .done   (md_done),
        .result (md_result)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_out   = alu_out_q;
    assign bus.alubranch = alubranch_q;
    assign busy          = (state != S_IDLE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed bench for alu_muldiv_iter (XLEN=32, STEP=1): base ops, M ops,
// special cases, backpressure, flush and reset abort.
module tb_alu_muldiv_iter;
    import exec_pkg::*;

    localparam int XLEN = 32;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   flush = 1'b0;
    logic   busy;
    state_t fsm_state;

    alu_muldiv_iter_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_iter #(
        .XLEN (XLEN),
        .STEP (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic f30,
                         input logic f25, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.opcode   = op;
        bus.func3    = f3;
        bus.func7_30 = f30;
        bus.func7_25 = f25;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic f30,
                        input logic f25, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int guard;
        drive(op, f3, f30, f25, a, b);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_wait", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [2:0] f3,
                          input logic f30, input logic f25,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_res, input logic exp_br, input int exp_lat);
        int lat;
        logic [XLEN-1:0] e;
        exp_q.push_back(exp_res);
        send(op, f3, f30, f25, a, b);
        wait_result(lat);
        e = exp_q.pop_front();
        check({tag, "_res"}, 64'(bus.alu_out), 64'(e));
        check({tag, "_br"}, 64'(bus.alubranch), 64'(exp_br));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.func3     = '0;
        bus.func7_30  = 1'b0;
        bus.func7_25  = 1'b0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_alu_out", 64'(bus.alu_out), 64'd0);
        check("rst_alubranch", 64'(bus.alubranch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));
        @(posedge clk); #1;

        // Base ALU
        run_op("sub",   OP_R, F3_ADD, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("sra",   OP_R, F3_SR, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        run_op("srai",  OP_I, F3_SR, 1'b1, 1'b0, 32'h8000_0000, 32'h404, 32'hF800_0000, 1'b0, 1);
        run_op("srl",   OP_R, F3_SR, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
        run_op("addi",  OP_I, F3_ADD, 1'b1, 1'b0, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 1);
        run_op("sll",   OP_R, F3_SLL, 1'b0, 1'b0, 32'd1, 32'd33, 32'd2, 1'b0, 1);
        run_op("slt",   OP_R, F3_SLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        run_op("sltu",  OP_R, F3_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        run_op("xor",   OP_I, F3_XOR, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        run_op("lui",   OP_LUI, 3'd0, 1'b0, 1'b0, 32'hDEAD_0000, 32'h1234_5000, 32'h1234_5000, 1'b0, 1);
        run_op("auipc", OP_AUIPC, 3'd0, 1'b0, 1'b0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 1);
        run_op("undef", 5'b11111, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1);

        // Branches and jumps
        run_op("blt",   OP_BRANCH, F3_BLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);
        run_op("bgeu",  OP_BRANCH, F3_BGEU, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        run_op("bne",   OP_BRANCH, F3_BNE, 1'b0, 1'b0, 32'd5, 32'd5, 32'd10, 1'b0, 1);
        run_op("jalr",  OP_JALR, 3'd0, 1'b0, 1'b0, 32'h100, 32'h20, 32'h104, 1'b1, 1);
        run_op("jal",   OP_JAL, 3'd0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h204, 1'b1, 1);

        // M extension, iterated
        run_op("mulh",   OP_R, F3_MULH, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
        run_op("mulhsu", OP_R, F3_MULHSU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("mulhu",  OP_R, F3_MULHU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        run_op("mul",    OP_R, F3_MUL, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
        run_op("div",    OP_R, F3_DIV, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem",    OP_R, F3_REM, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("divu",   OP_R, F3_DIVU, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        run_op("remu",   OP_R, F3_REMU, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0, 34);

        // Special cases bypass the iteration
        run_op("divu0",  OP_R, F3_DIVU, 1'b0, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("rem0",   OP_R, F3_REM, 1'b0, 1'b1, 32'd7, 32'd0, 32'd7, 1'b0, 1);
        run_op("divovf", OP_R, F3_DIV, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("removf", OP_R, F3_REM, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

        // Backpressure: result held, no accept, then retire + accept together
        begin
            int lat;
            bus.out_ready = 1'b0;
            send(OP_R, F3_ADD, 1'b0, 1'b0, 32'd3, 32'd4);
            wait_result(lat);
            drive(OP_R, F3_ADD, 1'b0, 1'b0, 32'd10, 32'd20);
            for (int i = 0; i < 5; i++) begin
                check("hold_alu_out", 64'(bus.alu_out), 64'd7);
                check("hold_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
            #1;
            check("release_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("b2b_out_valid", 64'(bus.out_valid), 64'd1);
            check("b2b_alu_out", 64'(bus.alu_out), 64'd30);
            @(posedge clk); #1;
            check("b2b_retired", 64'(bus.out_valid), 64'd0);
        end

        // Flush during DIVU, with a request presented in the flush cycle
        send(OP_R, F3_DIVU, 1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        drive(OP_R, F3_ADD, 1'b0, 1'b0, 32'd1, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_state", 64'(fsm_state), 64'(S_IDLE));
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) rises++;
        end
        check("flush_no_result", 64'(rises), 64'd0);

        // Reset in the middle of a MUL
        send(OP_R, F3_MUL, 1'b0, 1'b1, 32'd6, 32'd7);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2;
        check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_alu_out", 64'(bus.alu_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) rises++;
        end
        check("rstmid_no_result", 64'(rises), 64'd0);

        run_op("post_add", OP_R, F3_ADD, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1);
        run_op("post_mul", OP_R, F3_MUL, 1'b0, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
